// File: rtl/nibble_capture_if.sv
// Bus bundle for nibble_capture: serial shift side, word FIFO side and
// status/clear controls. clk and reset_n stay plain ports on the module.
interface nibble_capture_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          shift_en;
    logic          data_in;
    logic [3:0]    sr_data;
    logic          align_clr;
    logic [3:0]    word_data;
    logic          word_valid;
    logic          word_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          ovf_clr;
    logic          perr;

    // Capture block side
    modport slave (
        input  shift_en, data_in, sr_data, align_clr, word_ready, ovf_clr,
        output word_data, word_valid, fifo_count, overflow, perr
    );

    // Driver / consumer side
    modport master (
        output shift_en, data_in, sr_data, align_clr, word_ready, ovf_clr,
        input  word_data, word_valid, fifo_count, overflow, perr
    );
endinterface

// File: rtl/nibble_capture.sv
// nibble_capture: frames a serial bit stream (shadowing an upstream 4-bit
// shift register) into nibbles and queues them in a DEPTH-word FIFO.
// Optional feature macro: NIBBLE_PARITY_EN -- adds a 5th even-parity bit per
// frame and reports the per-word parity error on perr.
// DEPTH must be a power of two in 2..16 so pointers wrap naturally.
module nibble_capture #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    nibble_capture_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef NIBBLE_PARITY_EN
    localparam logic [2:0] LAST_BIT = 3'd4;
`else
    localparam logic [2:0] LAST_BIT = 3'd3;
`endif

    logic [2:0]    bit_cnt;
    logic          shift_ok;
    logic          data_done;
    logic          frame_done;
    logic [3:0]    nibble_now;
    logic [3:0]    push_word;
    logic          push_perr;

    logic [3:0]    mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          ovf_q;

    // A realignment clear swallows any coincident shift bit.
    assign shift_ok   = bus.shift_en & ~bus.align_clr;
    assign data_done  = shift_ok && (bit_cnt == 3'd3);
    assign frame_done = shift_ok && (bit_cnt == LAST_BIT);
    // sr_data is the pre-edge value, so splice in the incoming bit to get
    // the register contents after this edge.
    assign nibble_now = {bus.sr_data[2:0], bus.data_in};

    // Bit position within the current frame; wraps after the last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bit_cnt <= 3'd0;
        else if (bus.align_clr)
            bit_cnt <= 3'd0;
        else if (bus.shift_en)
            bit_cnt <= (bit_cnt == LAST_BIT) ? 3'd0 : bit_cnt + 3'd1;
    end

`ifdef NIBBLE_PARITY_EN
    logic [3:0] nib_q;
    logic       par_acc;
    logic       mem_perr [DEPTH];
    logic       unused_data_done;

    assign unused_data_done = data_done;

    // Hold the nibble from bit 4 and fold data bits into the parity sum
    // until the parity bit arrives on the following shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nib_q   <= 4'h0;
            par_acc <= 1'b0;
        end else if (bus.align_clr) begin
            par_acc <= 1'b0;
        end else if (shift_ok) begin
            if (bit_cnt == 3'd0)
                par_acc <= bus.data_in;
            else if (bit_cnt != LAST_BIT)
                par_acc <= par_acc ^ bus.data_in;
            if (data_done)
                nib_q <= nibble_now;
        end
    end

    assign push_word = nib_q;
    assign push_perr = par_acc ^ bus.data_in;

    // Parity flag storage alongside each word.
    always_ff @(posedge clk) begin
        if (push)
            mem_perr[wr_ptr] <= push_perr;
    end

    assign bus.perr = empty ? 1'b0 : mem_perr[rd_ptr];
`else
    logic unused_bits;

    assign unused_bits = ^{data_done, push_perr};
    assign push_word   = nibble_now;
    assign push_perr   = 1'b0;
    assign bus.perr    = 1'b0;
`endif

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot
    // on the same edge; an empty FIFO never pops the word being pushed.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = ~empty & bus.word_ready;
    assign push  = frame_done & (~full | pop);
    assign drop  = frame_done & full & ~pop;

    // Word storage; no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_data[wr_ptr] <= push_word;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Sticky overflow; a drop on the clearing edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf_q <= 1'b0;
        else if (drop)
            ovf_q <= 1'b1;
        else if (bus.ovf_clr)
            ovf_q <= 1'b0;
    end

    assign bus.word_valid = ~empty;
    assign bus.word_data  = empty ? 4'h0 : mem_data[rd_ptr];
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_nibble_capture.sv
// Bench for nibble_capture: directed scenarios plus randomized traffic,
// all checked each cycle against a frame/queue reference model.
module tb_nibble_capture;
    localparam int DEPTH = 4;
`ifdef NIBBLE_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Reference model state
    logic [4:0] q [$];        // {perr, word}
    int         nbits = 0;
    logic [3:0] acc = 4'h0;
    logic       ovf_m = 1'b0;
    logic [3:0] sr = 4'h0;    // upstream shift register

    nibble_capture_if #(.DEPTH(DEPTH)) bus();

    nibble_capture #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_valid"}, 32'(bus.word_valid), 32'(q.size() != 0));
        chk({tag, "_data"},  32'(bus.word_data),  (q.size() != 0) ? 32'(q[0][3:0]) : 32'h0);
        chk({tag, "_perr"},  32'(bus.perr),       (q.size() != 0) ? 32'(q[0][4]) : 32'h0);
        chk({tag, "_count"}, 32'(bus.fifo_count), 32'(q.size()));
        chk({tag, "_ovf"},   32'(bus.overflow),   32'(ovf_m));
    endtask

    // One clock: drive at negedge, update model after posedge, compare.
    task automatic cyc(input logic se, input logic din, input logic rdy,
                       input logic ac, input logic oc);
        logic popped;
        logic dropped;
        logic [4:0] w;
        @(negedge clk);
        bus.shift_en   = se;
        bus.data_in    = din;
        bus.word_ready = rdy;
        bus.align_clr  = ac;
        bus.ovf_clr    = oc;
        bus.sr_data    = sr;
        @(posedge clk);
        #1;
        popped  = 1'b0;
        dropped = 1'b0;
        if (rdy && q.size() != 0) begin
            void'(q.pop_front());
            popped = 1'b1;
        end
        if (se)
            sr = {sr[2:0], din};
        if (ac) begin
            nbits = 0;
        end else if (se) begin
            if (nbits < 4)
                acc = {acc[2:0], din};
            nbits++;
            if (nbits == FRAME) begin
                w = {1'b0, acc};
                if (FRAME == 5)
                    w[4] = (^acc) ^ din;
                nbits = 0;
                if (q.size() < DEPTH)
                    q.push_back(w);
                else
                    dropped = 1'b1;
            end
        end
        if (dropped)
            ovf_m = 1'b1;
        else if (oc)
            ovf_m = 1'b0;
        chk_all("cyc");
        if (popped && dropped)
            chk("pop_drop_model", 32'd1, 32'd0);
    endtask

    // Full frame, MSB first; ready only on the final bit edge.
    task automatic send_frame(input logic [3:0] nib, input logic rdy_last, input logic par_flip);
        for (int i = 3; i >= 0; i--)
            cyc(1'b1, nib[i], (FRAME == 4) ? rdy_last && i == 0 : 1'b0, 1'b0, 1'b0);
        if (FRAME == 5)
            cyc(1'b1, (^nib) ^ par_flip, rdy_last, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", 32'(bus.word_valid), 32'd0);
    endtask

    // Asynchronous reset mid-cycle, outputs checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        bus.shift_en = 1'b0; bus.data_in = 1'b0; bus.word_ready = 1'b0;
        bus.align_clr = 1'b0; bus.ovf_clr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        q.delete(); nbits = 0; ovf_m = 1'b0;
        chk("rst_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_data",  32'(bus.word_data),  32'd0);
        chk_all("rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.shift_en = 1'b0; bus.data_in = 1'b0; bus.word_ready = 1'b0;
        bus.align_clr = 1'b0; bus.ovf_clr = 1'b0; bus.sr_data = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("por_valid", 32'(bus.word_valid), 32'd0);
        chk("por_data",  32'(bus.word_data),  32'd0);
        chk("por_count", 32'(bus.fifo_count), 32'd0);
        chk("por_ovf",   32'(bus.overflow),   32'd0);
        chk("por_perr",  32'(bus.perr),       32'd0);
        reset_n = 1'b1;

        // First word 1011
        send_frame(4'hB, 1'b0, 1'b0);
        chk("first_valid", 32'(bus.word_valid), 32'd1);
        chk("first_data",  32'(bus.word_data),  32'hB);
        chk("first_count", 32'(bus.fifo_count), 32'd1);

        // Fill, then overflow on a 5th frame
        send_frame(4'h1, 1'b0, 1'b0);
        send_frame(4'h2, 1'b0, 1'b0);
        send_frame(4'h3, 1'b0, 1'b0);
        send_frame(4'h4, 1'b0, 1'b0);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        chk("ovf_set",   32'(bus.overflow),   32'd1);
        chk("ovf_head",  32'(bus.word_data),  32'hB);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr",   32'(bus.overflow),   32'd0);

        // Full FIFO: pop and push on the same edge
        send_frame(4'h5, 1'b1, 1'b0);
        chk("fullpp_count", 32'(bus.fifo_count), 32'd4);
        chk("fullpp_ovf",   32'(bus.overflow),   32'd0);
        chk("fullpp_head",  32'(bus.word_data),  32'h1);
        drain();

        // Partial frame discarded by align_clr
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(4'h6, 1'b0, 1'b0);
        chk("align_count", 32'(bus.fifo_count), 32'd1);
        chk("align_data",  32'(bus.word_data),  32'h6);
        drain();

        // Reset mid-frame with two words held
        send_frame(4'h7, 1'b0, 1'b0);
        send_frame(4'h8, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_frame(4'hF, 1'b0, 1'b0);
        chk("postrst_data",  32'(bus.word_data),  32'hF);
        chk("postrst_count", 32'(bus.fifo_count), 32'd1);
        drain();

`ifdef NIBBLE_PARITY_EN
        send_frame(4'hA, 1'b0, 1'b0);
        chk("par_ok_data", 32'(bus.word_data), 32'hA);
        chk("par_ok_perr", 32'(bus.perr),      32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(4'hA, 1'b0, 1'b1);
        chk("par_bad_data", 32'(bus.word_data), 32'hA);
        chk("par_bad_perr", 32'(bus.perr),      32'd1);
        drain();
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 9) < 7,
                1'($urandom),
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 5);
            if (n == 1500)
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
